// File: rtl/dcpu_bus_timer.sv
// Target-side responder on the dcpu memory bus: a four-register window holding a
// prescaled down-counter timer with a level interrupt, answered after programmable wait states.
module dcpu_bus_timer #(
   parameter logic [15:0] BASE_ADDR   = 16'hFF00,
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned PRESC_W     = 4
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic [15:0] i_addr,
   input  logic [15:0] i_dat,
   output logic [15:0] o_dat,
   input  logic        i_we,
   input  logic        i_cs,
   output logic        o_ack,
   output logic        o_int
);

   // A zero-width prescaler still needs one storage bit; its wrap value is then 0.
   localparam int unsigned   PW        = (PRESC_W > 0) ? PRESC_W : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'((2 ** PRESC_W) - 1);
   localparam logic [3:0]    WAIT_INIT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t        state_r, state_s;
   logic [3:0]    wcnt_r, wcnt_s;
   logic          ack_r, int_r;
   logic [15:0]   dat_r;
   logic          en_r, ie_r, auto_r, pend_r;
   logic [15:0]   reload_r, count_r;
   logic [PW-1:0] presc_r;
   logic          hit_s;
   logic [15:0]   rdata_s;
   logic          wr_s, wr_ctrl_s, wr_reload_s, wr_count_s, wr_status_s;
   logic          tick_s, expire_s;

   assign o_ack = ack_r;
   assign o_dat = dat_r;
   assign o_int = int_r;

   // Writes commit while ACK is showing; CPU still holds addr/dat/we then.
   assign wr_s        = (state_r == ST_ACK) & i_we;
   assign wr_ctrl_s   = wr_s & (i_addr[1:0] == 2'd0);
   assign wr_reload_s = wr_s & (i_addr[1:0] == 2'd1);
   assign wr_count_s  = wr_s & (i_addr[1:0] == 2'd2);
   assign wr_status_s = wr_s & (i_addr[1:0] == 2'd3);
   assign tick_s      = en_r & (presc_r == PRESC_MAX) & ~wr_ctrl_s & ~wr_count_s;
   assign expire_s    = tick_s & (count_r == 16'h0000);

   // Window decode and register read multiplexer.
   always_comb begin
      hit_s   = i_cs & (i_addr[15:2] == BASE_ADDR[15:2]);
      rdata_s = 16'h0000;
      case (i_addr[1:0])
         2'd0:    rdata_s = {13'h0000, auto_r, ie_r, en_r};
         2'd1:    rdata_s = reload_r;
         2'd2:    rdata_s = count_r;
         2'd3:    rdata_s = {15'h0000, pend_r};
         default: rdata_s = 16'h0000;
      endcase
   end

   // Bus handshake next-state logic.
   always_comb begin
      state_s = state_r;
      wcnt_s  = wcnt_r;
      case (state_r)
         ST_IDLE: begin
            if (hit_s) begin
               wcnt_s = WAIT_INIT;
               if (WAIT_STATES == 0) begin
                  state_s = ST_ACK;
               end else begin
                  state_s = ST_WAIT;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!i_cs) begin
               state_s = ST_IDLE;
            end else begin
               wcnt_s = wcnt_r - 4'd1;
               if (wcnt_r == 4'd1) begin
                  state_s = ST_ACK;
               end else begin
                  state_s = ST_WAIT;
               end
            end
         end
         ST_ACK:  state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Handshake state, acknowledge and read-data registers.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r <= ST_IDLE;
         wcnt_r  <= 4'd0;
         ack_r   <= 1'b0;
         dat_r   <= 16'h0000;
      end else begin
         state_r <= state_s;
         wcnt_r  <= wcnt_s;
         ack_r   <= (state_s == ST_ACK);
         if ((state_s == ST_ACK) && !i_we) begin
            dat_r <= rdata_s;
         end else begin
            dat_r <= 16'h0000;
         end
      end
   end

   // Prescaler: free-runs only while the timer is enabled.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         presc_r <= '0;
      end else if (!en_r || (presc_r == PRESC_MAX)) begin
         presc_r <= '0;
      end else begin
         presc_r <= presc_r + PW'(1);
      end
   end

   // Timer registers; a bus write to CTRL or COUNT swallows a coincident tick.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         en_r     <= 1'b0;
         ie_r     <= 1'b0;
         auto_r   <= 1'b0;
         reload_r <= 16'h0000;
         count_r  <= 16'h0000;
         pend_r   <= 1'b0;
         int_r    <= 1'b0;
      end else begin
         if (wr_ctrl_s) begin
            en_r   <= i_dat[0];
            ie_r   <= i_dat[1];
            auto_r <= i_dat[2];
         end else if (expire_s && !auto_r) begin
            en_r <= 1'b0;
         end
         if (wr_reload_s) begin
            reload_r <= i_dat;
         end
         // Auto-reload reads reload_r before a same-cycle RELOAD write lands.
         if (wr_count_s) begin
            count_r <= i_dat;
         end else if (tick_s) begin
            if (count_r != 16'h0000) begin
               count_r <= count_r - 16'h0001;
            end else if (auto_r) begin
               count_r <= reload_r;
            end
         end
         if (expire_s) begin
            pend_r <= 1'b1;
         end else if (wr_status_s && i_dat[0]) begin
            pend_r <= 1'b0;
         end
         int_r <= pend_r & ie_r;
      end
   end

endmodule

// File: tb/tb_dcpu_bus_timer.sv
// Bench for dcpu_bus_timer: register table, directed timing/collision sequences and
// randomized bus traffic compared cycle by cycle against a rule-level model.
module tb_dcpu_bus_timer;

   localparam logic [15:0] BASE = 16'hFF00;
   localparam int          WS   = 1;
   localparam int          PW   = 0;
   localparam int          PMAX = (1 << PW) - 1;

   logic        i_clk, i_reset_n, i_we, i_cs, o_ack, o_int;
   logic [15:0] i_addr, i_dat, o_dat;
   int          checks   = 0;
   int          failures = 0;

   // Reference model: timer registers as plain variables, bus as request age.
   bit          m_en, m_ie, m_auto, m_pend, m_ack, m_int;
   logic [15:0] m_reload, m_count, m_dat;
   int          m_pcnt, m_age;

   typedef struct {
      logic        we;
      logic [1:0]  off;
      logic [15:0] wd;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs[14];

   dcpu_bus_timer #(.BASE_ADDR(BASE), .WAIT_STATES(WS), .PRESC_W(PW)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_addr(i_addr), .i_dat(i_dat),
      .o_dat(o_dat), .i_we(i_we), .i_cs(i_cs), .o_ack(o_ack), .o_int(o_int)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_en = 0; m_ie = 0; m_auto = 0; m_pend = 0; m_ack = 0; m_int = 0;
      m_reload = 16'd0; m_count = 16'd0; m_dat = 16'd0; m_pcnt = 0; m_age = -1;
   endtask

   function automatic logic [15:0] model_read(input logic [1:0] off);
      case (off)
         2'd0:    return {13'd0, m_auto, m_ie, m_en};
         2'd1:    return m_reload;
         2'd2:    return m_count;
         default: return {15'd0, m_pend};
      endcase
   endfunction

   // One clock edge of the rules, all decisions taken from pre-edge values.
   task automatic model_step();
      bit          wr, tick, expire, nack;
      logic [1:0]  off;
      logic [15:0] ndat;
      if (!i_reset_n) begin
         model_reset();
         return;
      end
      off    = i_addr[1:0];
      wr     = m_ack && i_we;
      tick   = m_en && (m_pcnt == PMAX) && !(wr && (off == 2'd0 || off == 2'd2));
      expire = tick && (m_count == 16'd0);
      nack   = 1'b0;
      ndat   = 16'd0;
      if (m_ack) begin
         m_age = -1;
      end else if (m_age >= 0) begin
         if (!i_cs) m_age = -1;
         else begin
            m_age++;
            if (m_age >= WS) nack = 1'b1;
         end
      end else if (i_cs && (i_addr[15:2] == BASE[15:2])) begin
         m_age = 0;
         if (WS == 0) nack = 1'b1;
      end
      if (nack) begin
         m_age = -1;
         if (!i_we) ndat = model_read(off);
      end
      m_int  = m_pend && m_ie;
      m_pcnt = m_en ? (m_pcnt + 1) % (PMAX + 1) : 0;
      if (wr && off == 2'd2) m_count = i_dat;
      else if (tick) m_count = (m_count != 16'd0) ? m_count - 16'd1 : (m_auto ? m_reload : 16'd0);
      if (expire) m_pend = 1'b1;
      else if (wr && off == 2'd3 && i_dat[0]) m_pend = 1'b0;
      if (wr && off == 2'd0) begin
         m_en = i_dat[0]; m_ie = i_dat[1]; m_auto = i_dat[2];
      end else if (expire && !m_auto) begin
         m_en = 1'b0;
      end
      if (wr && off == 2'd1) m_reload = i_dat;
      m_ack = nack;
      m_dat = ndat;
   endtask

   task automatic cycle();
      @(posedge i_clk);
      model_step();
      @(negedge i_clk);
      check("cyc_ack", {15'd0, o_ack}, {15'd0, m_ack});
      check("cyc_dat", o_dat, m_dat);
      check("cyc_int", {15'd0, o_int}, {15'd0, m_int});
   endtask

   task automatic bus(input logic we, input logic [1:0] off, input logic [15:0] wd,
                      output logic [15:0] rd, output int lat);
      i_cs = 1'b1; i_we = we; i_addr = {BASE[15:2], off}; i_dat = wd;
      lat = 0; rd = 16'd0;
      for (int c = 1; c <= 16 && lat == 0; c++) begin
         cycle();
         if (o_ack) begin
            lat = c;
            rd  = o_dat;
         end
      end
      i_cs = 1'b0;
      if (lat == 0) begin
         checks++; failures++;
         $display("FAIL bus_timeout: no ack after 16 cycles, want ack at offset %0d", off);
      end else begin
         cycle();
      end
   endtask

   task automatic bus_wr(input logic [1:0] off, input logic [15:0] wd);
      logic [15:0] rd;
      int          lat;
      bus(1'b1, off, wd, rd, lat);
      check("wr_lat", 16'(lat), 16'(WS + 1));
      check("wr_dat_zero", rd, 16'd0);
   endtask

   task automatic bus_rd_chk(input string name, input logic [1:0] off, input logic [15:0] exp);
      logic [15:0] rd;
      int          lat;
      bus(1'b0, off, 16'd0, rd, lat);
      check("rd_lat", 16'(lat), 16'(WS + 1));
      check(name, rd, exp);
   endtask

   initial begin
      logic [15:0] rd;
      int          lat;
      bit          miss, abort, done;
      logic [1:0]  roff;

      i_reset_n = 1'b0; i_cs = 1'b0; i_we = 1'b0; i_addr = 16'd0; i_dat = 16'd0;
      model_reset();
      vecs[0]  = '{1'b1, 2'd0, 16'h0006, 16'h0000};
      vecs[1]  = '{1'b0, 2'd0, 16'h0000, 16'h0006};
      vecs[2]  = '{1'b1, 2'd0, 16'hFFF8, 16'h0000};
      vecs[3]  = '{1'b0, 2'd0, 16'h0000, 16'h0000};
      vecs[4]  = '{1'b1, 2'd1, 16'hA5A5, 16'h0000};
      vecs[5]  = '{1'b0, 2'd1, 16'h0000, 16'hA5A5};
      vecs[6]  = '{1'b1, 2'd2, 16'h8001, 16'h0000};
      vecs[7]  = '{1'b0, 2'd2, 16'h0000, 16'h8001};
      vecs[8]  = '{1'b1, 2'd3, 16'hFFFE, 16'h0000};
      vecs[9]  = '{1'b0, 2'd3, 16'h0000, 16'h0000};
      vecs[10] = '{1'b1, 2'd2, 16'h0000, 16'h0000};
      vecs[11] = '{1'b0, 2'd2, 16'h0000, 16'h0000};
      vecs[12] = '{1'b1, 2'd1, 16'h0000, 16'h0000};
      vecs[13] = '{1'b0, 2'd1, 16'h0000, 16'h0000};

      cycle();
      cycle();
      check("rst_ack", {15'd0, o_ack}, 16'd0);
      check("rst_dat", o_dat, 16'd0);
      check("rst_int", {15'd0, o_int}, 16'd0);
      i_reset_n = 1'b1;
      cycle();

      // Register table with the timer disabled.
      for (int k = 0; k < 14; k++) begin
         bus(vecs[k].we, vecs[k].off, vecs[k].wd, rd, lat);
         check("tbl_lat", 16'(lat), 16'(WS + 1));
         check("tbl_data", rd, vecs[k].exp);
      end

      // RELOAD write then back-to-back read.
      bus(1'b1, 2'd1, 16'h1234, rd, lat);
      check("reload_wr_lat", 16'(lat), 16'(WS + 1));
      bus(1'b0, 2'd1, 16'h0000, rd, lat);
      check("reload_b2b_lat", 16'(lat), 16'(WS + 1));
      check("reload_rd", rd, 16'h1234);

      // One-shot: expires on the 4th tick, interrupt one cycle after PEND.
      bus_wr(2'd2, 16'd3);
      bus_wr(2'd0, 16'h0003);
      repeat (4) cycle();
      check("oneshot_int_early", {15'd0, o_int}, 16'd0);
      cycle();
      check("oneshot_int", {15'd0, o_int}, 16'd1);
      bus_rd_chk("oneshot_ctrl", 2'd0, 16'h0002);
      bus_rd_chk("oneshot_count", 2'd2, 16'h0000);
      bus_rd_chk("oneshot_status", 2'd3, 16'h0001);
      bus_wr(2'd3, 16'h0001);

      // Auto-reload with period 3; the second clear lands exactly on an expiry.
      bus_wr(2'd1, 16'd2);
      bus_wr(2'd2, 16'd0);
      bus_wr(2'd0, 16'h0007);
      bus_wr(2'd3, 16'h0001);
      check("auto_int_before_drop", {15'd0, o_int}, 16'd1);
      cycle();
      check("auto_int_drop", {15'd0, o_int}, 16'd0);
      bus_wr(2'd3, 16'h0001);
      cycle();
      check("clear_vs_expire_int", {15'd0, o_int}, 16'd1);
      bus_wr(2'd0, 16'h0000);
      bus_wr(2'd3, 16'h0001);

      // COUNT written on a tick edge; the read samples it one tick later (5 -> 4).
      bus_wr(2'd2, 16'd100);
      bus_wr(2'd0, 16'h0001);
      bus_wr(2'd2, 16'd5);
      bus_rd_chk("count_write_vs_tick", 2'd2, 16'd4);

      // Misses while the timer finishes counting 2 -> 0 and expires.
      i_cs = 1'b1; i_we = 1'b0; i_addr = 16'h8000;
      for (int k = 0; k < 10; k++) begin
         cycle();
         check("miss_ack", {15'd0, o_ack}, 16'd0);
         check("miss_dat", o_dat, 16'd0);
      end
      i_cs = 1'b0;
      bus_rd_chk("miss_ctrl", 2'd0, 16'h0000);
      bus_rd_chk("miss_status", 2'd3, 16'h0001);
      bus_wr(2'd3, 16'h0001);

      // Randomized traffic against the model.
      for (int t = 0; t < 300; t++) begin
         miss  = ($urandom_range(0, 7) == 0);
         abort = ($urandom_range(0, 9) == 0);
         roff  = 2'($urandom_range(0, 3));
         i_we  = 1'($urandom_range(0, 1));
         i_dat = ((roff == 2'd1) || (roff == 2'd2)) ? 16'($urandom_range(0, 6)) : 16'($urandom);
         if (miss) begin
            i_addr = 16'($urandom);
            if (i_addr[15:2] == BASE[15:2]) i_addr[15] = ~i_addr[15];
         end else begin
            i_addr = {BASE[15:2], roff};
         end
         i_cs = 1'b1;
         done = 1'b0;
         for (int c = 0; c < 16 && !done; c++) begin
            cycle();
            if (m_ack) begin
               i_cs = 1'b0;
               cycle();
               done = 1'b1;
            end else if ((miss && c == 3) || (abort && WS > 0 && c == 0)) begin
               i_cs = 1'b0;
               cycle();
               done = 1'b1;
            end
         end
         i_cs = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            i_addr = 16'($urandom); i_dat = 16'($urandom); i_we = 1'($urandom_range(0, 1));
            cycle();
         end
      end

      // Reset in the middle of a read with the interrupt asserted.
      bus_wr(2'd1, 16'd0);
      bus_wr(2'd2, 16'd0);
      bus_wr(2'd0, 16'h0007);
      cycle();
      cycle();
      check("pre_reset_int", {15'd0, o_int}, 16'd1);
      i_cs = 1'b1; i_we = 1'b0; i_addr = {BASE[15:2], 2'd2};
      cycle();
      i_reset_n = 1'b0;
      model_reset();
      #1;
      check("mid_rst_ack", {15'd0, o_ack}, 16'd0);
      check("mid_rst_int", {15'd0, o_int}, 16'd0);
      check("mid_rst_dat", o_dat, 16'd0);
      i_cs = 1'b0;
      cycle();
      cycle();
      i_reset_n = 1'b1;
      repeat (3) begin
         cycle();
         check("post_rst_no_ack", {15'd0, o_ack}, 16'd0);
      end
      bus_rd_chk("post_rst_ctrl", 2'd0, 16'h0000);
      bus_rd_chk("post_rst_reload", 2'd1, 16'h0000);
      bus_rd_chk("post_rst_count", 2'd2, 16'h0000);
      bus_rd_chk("post_rst_status", 2'd3, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
